// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and field bounds for the LEGv8 fetch stage
// Contents: fetch_state_t FSM encoding, instruction width, opcode and
// immediate field bounds, and the branch offset word shift.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam int INSTR_W  = 32;

  // Decoder opcode field
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 21;

  // B/BL word offset
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  // CBZ/B.cond word offset
  localparam int IMM19_HI = 23;
  localparam int IMM19_LO = 5;

  // Branch immediates count words; shift by this to get a byte offset
  localparam int BR_SHIFT = 2;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC and BL link address generator
// Ports:
//   pc          in   current PC (address of instr)
//   instr       in   current instruction word
//   BrTaken     in   decoder: take branch
//   UncondBr    in   decoder: 1 = imm26 offset, 0 = imm19 offset
//   breg_sig    in   decoder: register branch (BR)
//   br_reg_val  in   register value for BR
//   next_pc     out  PC to fetch after this instruction
//   link_addr   out  pc + 4, BL return address
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               BrTaken,
  input  logic               UncondBr,
  input  logic               breg_sig,
  input  logic [ADDR_W-1:0]  br_reg_val,
  output logic [ADDR_W-1:0]  next_pc,
  output logic [ADDR_W-1:0]  link_addr
);

  localparam int IMM26_W = IMM26_HI - IMM26_LO + 1;
  localparam int IMM19_W = IMM19_HI - IMM19_LO + 1;

  logic [ADDR_W-1:0] off26;
  logic [ADDR_W-1:0] off19;
  logic [ADDR_W-1:0] pc_plus4;

  // Sign-extend the word offsets, then scale to bytes; all sums wrap modulo 2^ADDR_W
  assign off26    = {{(ADDR_W-IMM26_W){instr[IMM26_HI]}}, instr[IMM26_HI:IMM26_LO]} << BR_SHIFT;
  assign off19    = {{(ADDR_W-IMM19_W){instr[IMM19_HI]}}, instr[IMM19_HI:IMM19_LO]} << BR_SHIFT;
  assign pc_plus4 = pc + ADDR_W'(4);

  always_comb begin
    next_pc = pc_plus4;
    if (breg_sig) begin
      // Register targets are forced word-aligned
      next_pc = {br_reg_val[ADDR_W-1:BR_SHIFT], {BR_SHIFT{1'b0}}};
    end else if (BrTaken && UncondBr) begin
      next_pc = pc + off26;
    end else if (BrTaken) begin
      next_pc = pc + off19;
    end
  end

  assign link_addr = pc_plus4;

  // Opcode bits and the alignment bits of the BR target play no part here
  logic unused_bits;
  assign unused_bits = ^{instr[INSTR_W-1:IMM26_HI+1], br_reg_val[BR_SHIFT-1:0]};

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LEGv8 instruction fetch stage with req/ack memory port
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   imem_req/imem_addr     fetch request and address, held until imem_ack
//   imem_ack/imem_rdata    memory response and instruction word
//   instr/instr_valid      registered instruction to the decoder
//   pc_out/link_addr       PC of instr and pc_out + 4 for BL
//   stall                  downstream hold of the current instruction
//   BrTaken/UncondBr/breg_sig/br_reg_val  decoder branch controls
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               BrTaken,
  input  logic               UncondBr,
  input  logic               breg_sig,
  input  logic [ADDR_W-1:0]  br_reg_val,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  link_addr
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .pc        (pc),
    .instr     (instr),
    .BrTaken   (BrTaken),
    .UncondBr  (UncondBr),
    .breg_sig  (breg_sig),
    .br_reg_val(br_reg_val),
    .next_pc   (next_pc),
    .link_addr (link_addr)
  );

  // pc only changes when leaving ISSUE, so the address is stable while requesting
  assign imem_addr = pc;
  assign pc_out    = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (!imem_req) begin
            // First cycle out of reset: raise the request, any ack now is stale
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state       <= REQ;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        BrTaken;
  logic        UncondBr;
  logic        breg_sig;
  logic [63:0] br_reg_val;
  logic [63:0] pc_out;
  logic [63:0] link_addr;

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .BrTaken    (BrTaken),
    .UncondBr   (UncondBr),
    .breg_sig   (breg_sig),
    .br_reg_val (br_reg_val),
    .pc_out     (pc_out),
    .link_addr  (link_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents; unwritten words are filled randomly on first read
  logic [31:0] mem [logic [63:0]];

  function automatic logic [31:0] rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Architectural next-PC rule
  function automatic logic [63:0] m_next(input logic [63:0] pc, input logic [31:0] ins,
                                         input bit bt, input bit ub, input bit bs,
                                         input logic [63:0] rv);
    longint off;
    if (bs) return rv & ~64'd3;
    if (bt && ub) begin
      off = longint'($signed(ins[25:0])) * 4;
      return pc + off;
    end
    if (bt) begin
      off = longint'($signed(ins[23:5])) * 4;
      return pc + off;
    end
    return pc + 64'd4;
  endfunction

  // Model: which instruction is current, whether it is being offered, and
  // whether we are in the first cycle after reset (no request yet)
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_fresh;

  task automatic step(input bit ack, input bit stl, input bit bt, input bit ub,
                      input bit bs, input logic [63:0] rv);
    bit acc, leave;
    imem_ack   = ack;
    stall      = stl;
    BrTaken    = bt;
    UncondBr   = ub;
    breg_sig   = bs;
    br_reg_val = rv;
    imem_rdata = rd(imem_addr);
    acc   = !m_valid && !m_fresh && ack;
    leave = m_valid && !stl;
    @(posedge clk);
    #1;
    if (acc) begin
      m_instr = rd(m_pc);
      m_valid = 1'b1;
    end else if (leave) begin
      m_pc    = m_next(m_pc, m_instr, bt, ub, bs, rv);
      m_valid = 1'b0;
    end
    m_fresh = 1'b0;
    check("instr_valid", 64'(instr_valid), 64'(m_valid));
    check("link_addr", link_addr, m_pc + 64'd4);
    if (m_valid) begin
      check("instr", 64'(instr), 64'(m_instr));
      check("pc_out", pc_out, m_pc);
      check("req_in_issue", 64'(imem_req), 64'd0);
    end else begin
      check("req_fetching", 64'(imem_req), 64'd1);
      check("imem_addr", imem_addr, m_pc);
    end
  endtask

  task automatic fetch();
    for (int i = 0; i < 8 && !m_valid; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    if (!m_valid) check("fetch_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input bit bt, input bit ub, input bit bs, input logic [63:0] rv);
    step(1'b0, 1'b0, bt, ub, bs, rv);
  endtask

  task automatic goto_pc(input logic [63:0] a);
    fetch();
    issue(1'b0, 1'b0, 1'b1, a);
  endtask

  // Asynchronous reset mid-cycle with stale acks around it
  task automatic do_reset();
    #2 reset = 1'b1;
    imem_ack = 1'b1;
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc", pc_out, 64'h0);
    check("rst_link", link_addr, 64'h4);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_hold", 64'(imem_req), 64'd0);
    reset   = 1'b0;
    m_pc    = 64'h0;
    m_valid = 1'b0;
    m_fresh = 1'b1;
  endtask

  logic [63:0] seen_addr;

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    BrTaken = 1'b0; UncondBr = 1'b0; breg_sig = 1'b0; br_reg_val = '0;
    m_pc = '0; m_instr = '0; m_valid = 1'b0; m_fresh = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Sequential fetch, zero-wait memory
    mem[64'h0] = 32'h8B020020;
    mem[64'h4] = 32'hF8000020;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);   // ack in the reset-fall cycle ignored
    check("seq_addr0", imem_addr, 64'h0);
    fetch();
    check("seq_instr0", 64'(instr), 64'h8B020020);
    issue(1'b0, 1'b0, 1'b0, 64'h0);
    check("seq_addr1", imem_addr, 64'h4);
    fetch();
    check("seq_instr1", 64'(instr), 64'hF8000020);
    issue(1'b0, 1'b0, 1'b0, 64'h0);
    check("seq_addr2", imem_addr, 64'h8);

    // Reset mid-WAIT, release, ack after one cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("rel_addr", imem_addr, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("rel_valid", 64'(instr_valid), 64'd1);
    check("rel_pc", pc_out, 64'h0);
    check("rel_link", link_addr, 64'h4);
    issue(1'b0, 1'b0, 1'b0, 64'h0);

    // B with imm26 = -4 at 0x100
    goto_pc(64'h103);
    check("br_align", imem_addr, 64'h100);
    mem[64'h100] = 32'h17FFFFFC;
    fetch();
    issue(1'b1, 1'b1, 1'b0, 64'h0);
    check("b_target", imem_addr, 64'hF0);

    // CBZ imm19 = +3 at 0x40, taken then not taken
    mem[64'h40] = 32'hB4000060;
    goto_pc(64'h40);
    fetch();
    issue(1'b1, 1'b0, 1'b0, 64'h0);
    check("cbz_taken", imem_addr, 64'h4C);
    goto_pc(64'h40);
    fetch();
    issue(1'b0, 1'b0, 1'b0, 64'h0);
    check("cbz_not_taken", imem_addr, 64'h44);

    // BR / BL at 0x80
    goto_pc(64'h80);
    fetch();
    check("bl_link", link_addr, 64'h84);
    issue(1'b0, 1'b0, 1'b1, 64'h1237);
    check("br_target", imem_addr, 64'h1234);

    // Stall in ISSUE with BrTaken toggling, then a long WAIT
    fetch();
    seen_addr = pc_out;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'(i & 1), 1'b1, 1'b0, 64'h0);
    check("stall_pc_held", pc_out, seen_addr);
    issue(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h5550);
    check("wait_addr", imem_addr, seen_addr + 64'd4);
    fetch();
    issue(1'b0, 1'b0, 1'b0, 64'h0);

    // Wrap at the top of the address space
    goto_pc(64'hFFFF_FFFF_FFFF_FFFF);
    check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch();
    check("top_link", link_addr, 64'h0);
    issue(1'b0, 1'b0, 1'b0, 64'h0);
    check("wrap_addr", imem_addr, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rv;
      rv = ($urandom_range(0, 3) == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the LEGv8 datapath; sits directly upstream of the instruction decoder.
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory port.
- Presents instr[31:21] as the decoder opcode, then takes back the decoder's BrTaken/UncondBr/breg_sig to compute the next PC (PC+4, imm19/imm26 branch, or register branch).
- Also supplies the BL link value (PC+4).

Parameters:
- ADDR_W, 64, PC and address width.
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction to decoder (opcode = instr[31:21]).
- instr_valid  out  1  instr/pc_out valid; decoder outputs meaningful.
- stall  in  1  downstream not ready; hold current instruction.
- BrTaken  in  1  from decoder: take branch.
- UncondBr  in  1  from decoder: 1 = imm26 offset, 0 = imm19 offset.
- breg_sig  in  1  from decoder: target = br_reg_val (BR).
- br_reg_val  in  ADDR_W  register-file read of Rn for BR.
- pc_out  out  ADDR_W  PC of instr.
- link_addr  out  ADDR_W  pc_out+4, for BL write-back to X30.

Behaviour:
- Reset (async, any state): state=REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 while reset high.
  - An imem_ack arriving during reset, or in the cycle reset falls, is ignored.
  - First request is issued in the first clk edge cycle after reset deasserts.
- FSM states REQ, WAIT, ISSUE:
  - REQ: imem_req=1, imem_addr=pc. If imem_ack, capture imem_rdata into instr and go to ISSUE; else go to WAIT.
  - WAIT: imem_req=1, imem_addr=pc unchanged. On imem_ack, capture and go to ISSUE.
  - ISSUE: instr_valid=1, imem_req=0.
    - stall=1: stay in ISSUE; instr, pc_out and link_addr held bit-exact.
    - stall=0: pc <= next_pc, go to REQ; instr_valid drops next cycle.
- instr_valid is 1 only in ISSUE. Minimum fetch latency is 1 cycle from REQ to instr_valid, i.e. one instruction per 2 cycles with zero-wait memory.
- next_pc (combinational, sampled only in ISSUE with stall=0), priority order:
  1. breg_sig=1: {br_reg_val[ADDR_W-1:2], 2'b00}. Low bits are forced to 0 for alignment.
  2. BrTaken=1 and UncondBr=1: pc + (sign_extend(instr[25:0]) << 2).
  3. BrTaken=1 and UncondBr=0: pc + (sign_extend(instr[23:5]) << 2).
  4. Otherwise: pc + 4.
- Arithmetic: ADDR_W-bit two's complement, modulo 2^ADDR_W. pc+4 at all-ones-minus-3 wraps to 0; negative offsets wrap below 0 likewise.
- BrTaken/UncondBr/breg_sig are treated as don't-care (ignored) outside ISSUE.
- link_addr = pc_out + 4 at all times (wrap as above). Reset value is RESET_PC+4.
- stall asserted in REQ/WAIT has no effect; the fetch completes and the FSM waits in ISSUE.
- No speculative or back-to-back fetch; at most one outstanding request.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, ISSUE}.
  - INSTR_W=32.
  - Opcode field bounds OPC_HI=31, OPC_LO=21.
  - Immediate bounds IMM26 [25:0], IMM19 [23:5].
  - BR_SHIFT=2.
- Sub-module next_pc_calc (combinational):
  - Inputs: pc, instr, BrTaken, UncondBr, breg_sig, br_reg_val.
  - Outputs: next_pc, link_addr.
  - Unit-testable in isolation.

Test Plan:
1. Reset mid-WAIT, then release with ack after 1 cycle -> imem_req=0 during reset; after release imem_addr=0; instr_valid=1 the cycle after ack; pc_out=0, link_addr=4.
2. Sequential fetch, zero-wait memory, words ADD (0x8B020020) then STUR -> imem_addr sequence 0, 4, 8; instr_valid pulses every other cycle.
3. B at pc=0x100, instr=0x17FFFFFC (imm26=-4), BrTaken=1, UncondBr=1 -> next imem_addr=0xF0.
4. CBZ at pc=0x40, imm19=+3, BrTaken=1, UncondBr=0 -> next imem_addr=0x4C. Same instruction with BrTaken=0 -> 0x44.
5. BR with br_reg_val=0x1237 at pc=0x80, breg_sig=1 -> next imem_addr=0x1234. BL at pc=0x80 -> link_addr=0x84.
6. stall=1 for 3 ISSUE cycles while BrTaken toggles; WAIT held 4 cycles with imem_ack=0 -> instr/pc_out unchanged, no new imem_req during stall; imem_addr stable during WAIT. pc=64'hFFFF_FFFF_FFFF_FFFC not taken -> next imem_addr=0.
